sc_io_hub_p: RTL and testbench

SC_IO_HUB_P -- requirements
Module: sc_io_hub_p

---
 rtl/sc_io_hub_p_if.sv | 20 ++
 rtl/sc_io_hub_p.sv | 171 +++++++++++++++++
 tb/tb_sc_io_hub_p.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sc_io_hub_p_if.sv
// CPU-side bus between the core, data memory and the I/O hub.
// The master side bundles the CPU and the data-memory load port, as a driver would see them.
interface sc_io_hub_p_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output addr, wdata, we, mem_rdata,
        input  rdata, mem_we
    );

    modport slave (
        input  addr, wdata, we, mem_rdata,
        output rdata, mem_we
    );
endinterface

// File: rtl/sc_io_hub_p.sv
// Memory-mapped I/O hub: LEDs, hex displays, synchronized switches, debounced keys
// with edge capture, and a free-running compare timer in a 256-byte window.
module sc_io_hub_p #(
    parameter int unsigned NUM_LED  = 10,
    parameter int unsigned NUM_HEX  = 6,
    parameter int unsigned NUM_SW   = 10,
    parameter int unsigned NUM_KEY  = 4,
    parameter logic [31:0] IO_BASE  = 32'hFFFF_FF00,
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    sc_io_hub_p_if.slave         bus,
    output logic [NUM_LED-1:0]   led,
    output logic [7*NUM_HEX-1:0] hex,
    input  logic [NUM_SW-1:0]    sw,
    input  logic [NUM_KEY-1:0]   key
);
    localparam int unsigned    CntW    = $clog2(DEBOUNCE + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

    localparam logic [5:0] WLed    = 6'h00;
    localparam logic [5:0] WHex    = 6'h01;
    localparam logic [5:0] WSw     = 6'h02;
    localparam logic [5:0] WKey    = 6'h03;
    localparam logic [5:0] WEdge   = 6'h04;
    localparam logic [5:0] WTcount = 6'h05;
    localparam logic [5:0] WTcmp   = 6'h06;
    localparam logic [5:0] WStatus = 6'h07;

    logic [NUM_LED-1:0]           led_q, led_d;
    logic [4*NUM_HEX-1:0]         hex_q, hex_d;
    logic [NUM_SW-1:0]            sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [NUM_KEY-1:0]           key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [NUM_KEY-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [NUM_KEY-1:0]           stable_q, stable_d;
    logic [NUM_KEY-1:0]           edge_q, edge_d;
    logic [31:0]                  tcount_q, tcount_d;
    logic [31:0]                  tcmp_q, tcmp_d;
    logic                         status_q, status_d;

    logic        io_sel;
    logic        wr_en;
    logic [5:0]  word;
    logic        match;
    logic [NUM_KEY-1:0] edge_clr;
    logic [31:0] rd_reg;
    logic        unused_addr;

    assign io_sel      = (bus.addr[31:8] == IO_BASE[31:8]);
    assign wr_en       = bus.we & io_sel;
    assign word        = bus.addr[7:2];
    assign bus.mem_we  = bus.we & ~io_sel;
    assign unused_addr = ^bus.addr[1:0];

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        led_d    = led_q;
        hex_d    = hex_q;
        tcmp_d   = tcmp_q;
        sw_s1_d  = sw;
        sw_s2_d  = sw_s1_q;
        key_s1_d = ~key;
        key_s2_d = key_s1_q;
        edge_clr = '0;

        if (wr_en && word == WLed)  led_d  = bus.wdata[NUM_LED-1:0];
        if (wr_en && word == WHex)  hex_d  = bus.wdata[4*NUM_HEX-1:0];
        if (wr_en && word == WTcmp) tcmp_d = bus.wdata;
        if (wr_en && word == WEdge) edge_clr = bus.wdata[NUM_KEY-1:0];

        // Match uses the pre-write count; a software write still wins the next value.
        match    = (tcount_q == tcmp_q);
        tcount_d = match ? 32'd0 : tcount_q + 32'd1;
        if (wr_en && word == WTcount) tcount_d = bus.wdata;
        status_d = (status_q & ~(wr_en && word == WStatus && bus.wdata[0])) | match;

        for (int k = 0; k < int'(NUM_KEY); k++) begin
            cnt_d[k]    = cnt_q[k];
            stable_d[k] = stable_q[k];
            if (key_s2_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CntMax) begin
                stable_d[k] = ~stable_q[k];
                cnt_d[k]    = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CntW'(1);
            end
        end

        // Set wins over a same-cycle clear.
        edge_d = (edge_q & ~edge_clr) | (stable_d & ~stable_q);
    end

    always_comb begin
        rd_reg = '0;
        case (word)
            WLed:    rd_reg[NUM_LED-1:0]   = led_q;
            WHex:    rd_reg[4*NUM_HEX-1:0] = hex_q;
            WSw:     rd_reg[NUM_SW-1:0]    = sw_s2_q;
            WKey:    rd_reg[NUM_KEY-1:0]   = stable_q;
            WEdge:   rd_reg[NUM_KEY-1:0]   = edge_q;
            WTcount: rd_reg                = tcount_q;
            WTcmp:   rd_reg                = tcmp_q;
            WStatus: rd_reg[0]             = status_q;
            default: rd_reg                = '0;
        endcase
        bus.rdata = io_sel ? rd_reg : bus.mem_rdata;
    end

    // Outputs are forced to their reset appearance while reset is held, before the first edge.
    always_comb begin
        led = reset ? '0 : led_q;
        hex = '0;
        for (int i = 0; i < int'(NUM_HEX); i++) begin
            hex[7*i +: 7] = reset ? 7'b1000000 : seg7(hex_q[4*i +: 4]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q    <= '0;
            hex_q    <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_s1_q <= '0;
            key_s2_q <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            edge_q   <= '0;
            tcount_q <= '0;
            tcmp_q   <= 32'hFFFF_FFFF;
            status_q <= 1'b0;
        end else begin
            led_q    <= led_d;
            hex_q    <= hex_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            key_s1_q <= key_s1_d;
            key_s2_q <= key_s2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            edge_q   <= edge_d;
            tcount_q <= tcount_d;
            tcmp_q   <= tcmp_d;
            status_q <= status_d;
        end
    end
endmodule

// File: tb/tb_sc_io_hub_p.sv
// Directed bench for sc_io_hub_p with default parameters (DEBOUNCE = 16).
module tb_sc_io_hub_p;
    localparam logic [31:0] IoBase = 32'hFFFF_FF00;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  led;
    logic [41:0] hex;
    logic [9:0]  sw;
    logic [3:0]  key;
    logic [31:0] rv;
    int n_total = 0;
    int n_pass  = 0;

    sc_io_hub_p_if bus ();

    sc_io_hub_p #(
        .NUM_LED (10),
        .NUM_HEX (6),
        .NUM_SW  (10),
        .NUM_KEY (4),
        .IO_BASE (IoBase),
        .DEBOUNCE(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus),
        .led  (led),
        .hex  (hex),
        .sw   (sw),
        .key  (key)
    );

    always #50 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic io_wr(input logic [7:0] off, input logic [31:0] data);
        bus.addr  = IoBase | {24'd0, off};
        bus.wdata = data;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] v;
        bus.addr = IoBase | {24'd0, off};
        #1;
        v = bus.rdata;
        check(tag, v, exp);
    endtask

    task automatic check_digit(input string tag, input int i, input logic [6:0] exp);
        logic [6:0] d;
        d = hex[7*i +: 7];
        check(tag, {25'd0, d}, {25'd0, exp});
    endtask

    initial begin
        reset         = 1'b1;
        key           = 4'hF;
        sw            = '0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.we        = 1'b0;
        bus.mem_rdata = '0;
        #1;
        check("rst_led_port", {22'd0, led}, 32'd0);
        check_digit("rst_hex_d0", 0, 7'b1000000);
        check_digit("rst_hex_d5", 5, 7'b1000000);
        bus.addr = 32'h0000_0010;
        bus.we   = 1'b1;
        #1;
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd1);
        bus.we = 1'b0;

        tick();
        check_rd("rst_tcmp", 8'h18, 32'hFFFF_FFFF);
        check_rd("rst_tcount", 8'h14, 32'd0);
        check_rd("rst_led", 8'h00, 32'd0);
        check_rd("rst_edge", 8'h10, 32'd0);
        check_rd("rst_status", 8'h1C, 32'd0);
        tick();
        reset = 1'b0;

        // LED / HEX stores
        io_wr(8'h00, 32'h0000_03FF);
        bus.addr  = IoBase | 32'h04;
        bus.wdata = 32'h00AB_CDEF;
        bus.we    = 1'b1;
        #1;
        check("io_mem_we", {31'd0, bus.mem_we}, 32'd0);
        tick();
        bus.we = 1'b0;
        check("led_port", {22'd0, led}, 32'h3FF);
        check_rd("led_reg", 8'h00, 32'h3FF);
        check_rd("hex_reg", 8'h04, 32'h00AB_CDEF);
        check_digit("hex_d5_A", 5, 7'b0001000);
        check_digit("hex_d4_b", 4, 7'b0000011);
        check_digit("hex_d3_C", 3, 7'b1000110);
        check_digit("hex_d2_d", 2, 7'b0100001);
        check_digit("hex_d1_E", 1, 7'b0000110);
        check_digit("hex_d0_F", 0, 7'b0001110);
        io_wr(8'h20, 32'hDEAD_BEEF);
        check_rd("unmapped", 8'h20, 32'd0);

        // Memory store passes through
        bus.addr      = 32'h0000_0010;
        bus.wdata     = 32'd0;
        bus.mem_rdata = 32'h1234_5678;
        bus.we        = 1'b1;
        #1;
        check("mem_we", {31'd0, bus.mem_we}, 32'd1);
        check("mem_rdata", bus.rdata, 32'h1234_5678);
        tick();
        bus.we = 1'b0;
        check_rd("led_after_mem", 8'h00, 32'h3FF);

        // Switch synchronizer latency
        sw[9] = 1'b1;
        tick();
        check_rd("sw_1cyc", 8'h08, 32'd0);
        tick();
        check_rd("sw_2cyc", 8'h08, 32'h200);
        io_wr(8'h08, 32'd0);
        check_rd("sw_ro", 8'h08, 32'h200);
        sw[9] = 1'b0;
        tick();
        check_rd("sw_fall_1", 8'h08, 32'h200);
        tick();
        check_rd("sw_fall_2", 8'h08, 32'd0);

        // Timer with TCMP = 3
        io_wr(8'h18, 32'd3);
        io_wr(8'h14, 32'd0);
        io_wr(8'h1C, 32'd1);
        check_rd("tc_1", 8'h14, 32'd1);
        check_rd("st_clear", 8'h1C, 32'd0);
        tick();
        tick();
        check_rd("tc_3", 8'h14, 32'd3);
        check_rd("st_pre", 8'h1C, 32'd0);
        tick();
        check_rd("tc_wrap", 8'h14, 32'd0);
        check_rd("st_wrap", 8'h1C, 32'd1);
        repeat (3) tick();
        check_rd("tc_3b", 8'h14, 32'd3);
        io_wr(8'h1C, 32'd1);
        check_rd("tc_wrap2", 8'h14, 32'd0);
        check_rd("st_w1c_match", 8'h1C, 32'd1);
        io_wr(8'h1C, 32'd1);
        check_rd("st_w1c", 8'h1C, 32'd0);
        check_rd("tc_after", 8'h14, 32'd1);

        // TCMP = 0 holds the count at zero
        io_wr(8'h18, 32'd0);
        io_wr(8'h14, 32'd0);
        tick();
        check_rd("tc0_hold", 8'h14, 32'd0);
        check_rd("tc0_status", 8'h1C, 32'd1);
        io_wr(8'h1C, 32'd1);
        check_rd("tc0_w1c", 8'h1C, 32'd1);
        check_rd("tc0_hold2", 8'h14, 32'd0);

        // Key debounce: accepted on the 18th edge after the press
        key[0] = 1'b0;
        repeat (17) tick();
        check_rd("key_early", 8'h0C, 32'd0);
        check_rd("edge_early", 8'h10, 32'd0);
        tick();
        check_rd("key_press", 8'h0C, 32'd1);
        check_rd("edge_set", 8'h10, 32'd1);
        key[0] = 1'b1;
        repeat (5) tick();
        key[0] = 1'b0;
        repeat (10) tick();
        check_rd("key_glitch", 8'h0C, 32'd1);
        check_rd("edge_glitch", 8'h10, 32'd1);
        io_wr(8'h10, 32'd1);
        check_rd("edge_w1c", 8'h10, 32'd0);
        check_rd("key_held", 8'h0C, 32'd1);

        // Reset mid-count and mid-debounce
        key[0] = 1'b1;
        io_wr(8'h18, 32'd100);
        io_wr(8'h14, 32'd3);
        tick();
        tick();
        check_rd("tc_5", 8'h14, 32'd5);
        check_rd("key_mid", 8'h0C, 32'd1);
        reset = 1'b1;
        tick();
        check_rd("rst2_tcount", 8'h14, 32'd0);
        check_rd("rst2_tcmp", 8'h18, 32'hFFFF_FFFF);
        check_rd("rst2_key", 8'h0C, 32'd0);
        check_rd("rst2_edge", 8'h10, 32'd0);
        check_rd("rst2_led", 8'h00, 32'd0);
        check("rst2_led_port", {22'd0, led}, 32'd0);
        reset = 1'b0;
        repeat (20) tick();
        check_rd("post_key", 8'h0C, 32'd0);
        check_rd("post_edge", 8'h10, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
